syndrome_check_pp: RTL



---
 rtl/syndrome_check_pp_pkg.sv | 18 +
 rtl/app_bank_ram.sv | 23 ++
 rtl/syndrome_check_pp.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/syndrome_check_pp_pkg.sv
// Shared types and width helpers for the syndrome checker and its drain path.
package syndrome_check_pp_pkg;

    typedef enum logic [1:0] {
        DRN_IDLE,
        DRN_READ,
        DRN_STREAM
    } drain_state_t;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

    // Width needed to hold values 0..n-1, never below one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/app_bank_ram.sv
// Simple dual-port APP storage: one write port, one registered read port (read-first).
module app_bank_ram #(
    parameter int DEPTH = 100,
    parameter int WIDTH = 127,
    parameter int AW    = 7
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/syndrome_check_pp.sv
// Incremental LDPC syndrome checker with ping-pong APP banks and a skid-buffered drain.
// Optional registered syndrome weight output: define SYNDROME_WEIGHT_EN.
module syndrome_check_pp
    import syndrome_check_pp_pkg::*;
#(
    parameter int BLK_SIZE     = 127,
    parameter int GF_SIZE_LOG2 = 7,
    parameter int PCM_ROWN     = 4,
    parameter int PCM_COLN     = 100,
    parameter int COL_CNT_WID  = 7,
    parameter int ET_PASS_CNT  = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_decoding,
    input  logic                             i_iter_end,
    input  logic                             i_decode_end,
    input  logic [BLK_SIZE-1:0]              i_app,
    input  logic [COL_CNT_WID-1:0]           i_col_cnt,
    input  logic [COL_CNT_WID-1:0]           i_rd_col,
    input  logic [GF_SIZE_LOG2*PCM_ROWN-1:0] i_shift_offset,
    output logic                             o_syn_zero,
    output logic                             o_et_req,
    output logic                             o_busy,
    output logic                             o_err,
    output logic [BLK_SIZE-1:0]              o_info,
    output logic                             o_info_valid,
    input  logic                             i_info_ready,
    output logic                             o_info_last
`ifdef SYNDROME_WEIGHT_EN
    ,
    output logic [$clog2(BLK_SIZE*PCM_ROWN+1)-1:0] o_syn_weight
`endif
);

    localparam int PASS_W = cnt_w(ET_PASS_CNT + 1);
    localparam logic [PASS_W-1:0]      PASS_MAX = PASS_W'(ET_PASS_CNT);
    localparam logic [COL_CNT_WID-1:0] LAST_COL = COL_CNT_WID'(PCM_COLN - 1);

    function automatic logic [BLK_SIZE-1:0] rotl(input logic [BLK_SIZE-1:0] x, input int unsigned s);
        return (x << s) | (x >> (BLK_SIZE - s));
    endfunction

    logic decode_acc, upd;
    logic wr_bank, first_iter, iter_end_q, et_req_q, err_q;
    logic [PASS_W-1:0] pass_cnt, pass_nxt;
    logic [PCM_ROWN-1:0][BLK_SIZE-1:0] checksum_q;
    logic [1:0] we;
    logic [1:0][COL_CNT_WID-1:0] raddr;
    logic [1:0][BLK_SIZE-1:0] rdata;
    logic [BLK_SIZE-1:0] diff, drain_data;

    drain_state_t state_q, state_d;
    logic rd_issue, rd_pend, rd_last_q, iss_done, pop, push, room;
    logic [COL_CNT_WID-1:0] iss_addr;
    logic [SKID_DEPTH-1:0][BLK_SIZE-1:0] sk_data;
    logic [SKID_DEPTH-1:0] sk_last;
    logic [SKID_CNT_W-1:0] sk_cnt, occ;

    assign decode_acc = i_decode_end & ~o_busy;
    assign upd        = i_decoding & ~i_decode_end;

    // The active bank follows the decoder; the other bank is read by the drain.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic BSEL = 1'(b);
        assign we[b]    = upd & (wr_bank == BSEL);
        assign raddr[b] = (wr_bank == BSEL) ? i_rd_col : iss_addr;
        app_bank_ram #(.DEPTH(PCM_COLN), .WIDTH(BLK_SIZE), .AW(COL_CNT_WID)) u_ram (
            .clk  (clk),
            .we   (we[b]),
            .waddr(i_col_cnt),
            .wdata(i_app),
            .raddr(raddr[b]),
            .rdata(rdata[b])
        );
    end

    assign diff       = first_iter ? i_app : (rdata[wr_bank] ^ i_app);
    assign drain_data = rdata[~wr_bank];
    assign o_syn_zero = ~|checksum_q;
    assign pass_nxt   = o_syn_zero ? ((pass_cnt == PASS_MAX) ? pass_cnt : pass_cnt + 1'b1) : '0;

    always_ff @(posedge clk) begin
        if (rst || decode_acc) begin
            checksum_q <= '0;
        end else if (upd) begin
            for (int r = 0; r < PCM_ROWN; r++)
                checksum_q[r] <= checksum_q[r] ^
                    rotl(diff, 32'(i_shift_offset[GF_SIZE_LOG2*r +: GF_SIZE_LOG2]) % BLK_SIZE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank    <= 1'b0;
            first_iter <= 1'b1;
            iter_end_q <= 1'b0;
            pass_cnt   <= '0;
            et_req_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            iter_end_q <= upd & i_iter_end;
            if (i_decode_end && o_busy)
                err_q <= 1'b1;
            if (decode_acc) begin
                wr_bank    <= ~wr_bank;
                first_iter <= 1'b1;
                pass_cnt   <= '0;
                et_req_q   <= 1'b0;
            end else begin
                if (upd && i_iter_end)
                    first_iter <= 1'b0;
                if (iter_end_q) begin
                    pass_cnt <= pass_nxt;
                    if (pass_nxt >= PASS_MAX)
                        et_req_q <= 1'b1;
                end
            end
        end
    end

    assign o_et_req = et_req_q;
    assign o_err    = err_q;

    // Reads are issued only when the skid will have room when the data lands.
    assign pop  = o_info_valid & i_info_ready;
    assign push = rd_pend;
    assign occ  = sk_cnt + {{(SKID_CNT_W-1){1'b0}}, rd_pend};
    assign room = (occ < SKID_CNT_W'(SKID_DEPTH)) | ((occ == SKID_CNT_W'(SKID_DEPTH)) & pop);

    always_comb begin
        state_d  = state_q;
        rd_issue = 1'b0;
        case (state_q)
            DRN_IDLE:   if (decode_acc) state_d = DRN_READ;
            DRN_READ: begin
                rd_issue = 1'b1;
                state_d  = DRN_STREAM;
            end
            DRN_STREAM: begin
                rd_issue = ~iss_done & room;
                if (pop && sk_last[0])
                    state_d = DRN_IDLE;
            end
            default:    state_d = DRN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DRN_IDLE;
            rd_pend   <= 1'b0;
            rd_last_q <= 1'b0;
            iss_addr  <= '0;
            iss_done  <= 1'b0;
            sk_cnt    <= '0;
            sk_data   <= '0;
            sk_last   <= '0;
        end else begin
            state_q   <= state_d;
            rd_pend   <= rd_issue;
            rd_last_q <= rd_issue & (iss_addr == LAST_COL);
            if (state_q == DRN_IDLE) begin
                iss_addr <= '0;
                iss_done <= 1'b0;
            end else if (rd_issue) begin
                iss_addr <= iss_addr + 1'b1;
                if (iss_addr == LAST_COL)
                    iss_done <= 1'b1;
            end
            case ({push, pop})
                2'b10: begin
                    sk_data[sk_cnt[0]] <= drain_data;
                    sk_last[sk_cnt[0]] <= rd_last_q;
                    sk_cnt             <= sk_cnt + 1'b1;
                end
                2'b01: begin
                    sk_data[0] <= sk_data[1];
                    sk_last[0] <= sk_last[1];
                    sk_cnt     <= sk_cnt - 1'b1;
                end
                2'b11: begin
                    if (sk_cnt == SKID_CNT_W'(1)) begin
                        sk_data[0] <= drain_data;
                        sk_last[0] <= rd_last_q;
                    end else begin
                        sk_data[0] <= sk_data[1];
                        sk_last[0] <= sk_last[1];
                        sk_data[1] <= drain_data;
                        sk_last[1] <= rd_last_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy       = (state_q != DRN_IDLE);
    assign o_info       = sk_data[0];
    assign o_info_valid = (sk_cnt != '0);
    assign o_info_last  = o_info_valid & sk_last[0];

`ifdef SYNDROME_WEIGHT_EN
    localparam int WGT_W = $clog2(BLK_SIZE*PCM_ROWN+1);
    logic [WGT_W-1:0] wgt;

    always_comb begin
        wgt = '0;
        for (int r = 0; r < PCM_ROWN; r++)
            for (int i = 0; i < BLK_SIZE; i++)
                wgt = wgt + WGT_W'(checksum_q[r][i]);
    end

    always_ff @(posedge clk) begin
        if (rst) o_syn_weight <= '0;
        else     o_syn_weight <= wgt;
    end
`endif

endmodule
